output_vc_credit_ctrl: RTL
==========================

OUTPUT_VC_CREDIT_CTRL -- requirements
Module: output_vc_credit_ctrl

Interface
REQ-001 SHALL have parameter VC_NUM, default 6; number of downstream VCs on the output port.
REQ-002 SHALL have parameter VC_DEPTH, default 4; buffer slots (credits) per downstream VC.
REQ-003 SHALL have derived localparam CNT_W = $clog2(VC_DEPTH+1); VC id width fixed at 3, QoS width fixed at 4.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_vld_i  input  1  global switch-allocation winner valid.
REQ-007 SHALL have port req_vc_id_i  input  3  downstream VC requested by the winner.
REQ-008 SHALL have port req_qos_i  input  4  QoS value of the winner.
REQ-009 SHALL have port grant_vld_o  output  1  VC assignment accepted this cycle; drives the arbiter update input.
REQ-010 SHALL have port st_vld_o  output  1  registered switch-traversal valid.
REQ-011 SHALL have port st_vc_id_o  output  3  registered granted VC id.
REQ-012 SHALL have port st_qos_o  output  4  registered granted QoS.
REQ-013 SHALL have port credit_ret_vld_i  input  1  downstream credit return valid.
REQ-014 SHALL have port credit_ret_vc_id_i  input  3  VC receiving the returned credit.
REQ-015 SHALL have port vc_avail_o  output  VC_NUM  bit v set when credit count of VC v is nonzero.
REQ-016 SHALL have port credit_cnt_o  output  VC_NUM*CNT_W  packed credit counts, VC v at bits [v*CNT_W +: CNT_W].
REQ-017 SHALL have port err_o  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL hold one CNT_W-bit credit counter per VC, range 0..VC_DEPTH.
REQ-019 SHALL assert grant_vld_o combinationally when req_vld_i=1, req_vc_id_i<VC_NUM, and counter[req_vc_id_i]>0; zero-cycle latency.
REQ-020 SHALL decrement counter[req_vc_id_i] by 1 on each clock edge where grant_vld_o=1.
REQ-021 SHALL increment counter[credit_ret_vc_id_i] by 1 on each edge where credit_ret_vld_i=1 and credit_ret_vc_id_i<VC_NUM and the counter is <VC_DEPTH.
REQ-022 SHALL leave the counter unchanged when grant and return target the same VC in the same cycle (net zero, no error, even at count 0 or VC_DEPTH).
REQ-023 SHALL update two different counters independently when grant and return target different VCs in the same cycle.
REQ-024 SHALL, on a return to a VC already at VC_DEPTH (no simultaneous grant to it), saturate the counter at VC_DEPTH and set err_o.
REQ-025 SHALL, on req_vld_i=1 with req_vc_id_i>=VC_NUM, not grant and set err_o.
REQ-026 SHALL ignore and set err_o on credit_ret_vld_i=1 with credit_ret_vc_id_i>=VC_NUM.
REQ-027 SHALL keep err_o set until reset; no other clear path.
REQ-028 SHALL, on req_vld_i=1 to a VC with count 0, deassert grant_vld_o with no state change and no error (request retried by upstream).
REQ-029 SHALL register st_vld_o<=grant_vld_o, and on grant st_vc_id_o<=req_vc_id_i, st_qos_o<=req_qos_i; one-cycle latency; st_vc_id_o/st_qos_o hold when no grant.
REQ-030 SHALL derive vc_avail_o and credit_cnt_o from the current registered counters (post-edge values, no bypass of same-cycle returns).
REQ-031 SHALL not let a same-cycle credit return enable a grant to a VC whose registered count is 0.

Reset
REQ-032 SHALL, on rstn low, asynchronously set all counters to VC_DEPTH, st_vld_o=0, st_vc_id_o=0, st_qos_o=0, err_o=0.
REQ-033 SHALL, with rstn low, hold grant_vld_o=0 regardless of req_vld_i.
REQ-034 SHALL, on reset asserted mid-operation, discard any in-flight st_* stage and return to REQ-032 values; first grant possible in the first cycle after rstn rises.

Verification
REQ-035 SHALL cover: after reset, req_vld_i=1, vc=2 for 5 consecutive cycles, no returns -> grant_vld_o=1 for 4 cycles then 0; credit_cnt[2]=0, vc_avail_o[2]=0, st_vld_o mirrors grants one cycle late.
REQ-036 SHALL cover: counter[1]=0, cycle N: req vc=1 and return vc=1 -> grant_vld_o=0 in N, counter[1]=1 after N, grant in N+1.
REQ-037 SHALL cover: counter[3]=4 (full), same-cycle grant vc=3 and return vc=3 -> grant_vld_o=1, counter[3] stays 4, err_o=0.
REQ-038 SHALL cover: counter[0]=4, return vc=0 alone -> counter stays 4, err_o=1 and remains 1 until rstn low.
REQ-039 SHALL cover: req_vc_id_i=7 with VC_NUM=6 -> grant_vld_o=0, err_o=1; return vc=6 -> no counter changes.
REQ-040 SHALL cover: rstn pulsed low while st_vld_o=1 and counters partially drained -> st_vld_o=0, all counters=4, err_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/output_vc_credit_ctrl.sv
// Output-port credit tracker: one credit counter per downstream VC, zero-latency
// grant of the switch-allocation winner, and a registered switch-traversal stage.
module output_vc_credit_ctrl #(
    parameter int unsigned VC_NUM   = 6,
    parameter int unsigned VC_DEPTH = 4,
    localparam int unsigned CNT_W   = $clog2(VC_DEPTH + 1),
    localparam int unsigned VC_W    = 3,
    localparam int unsigned QOS_W   = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_vld_i,
    input  logic [VC_W-1:0]          req_vc_id_i,
    input  logic [QOS_W-1:0]         req_qos_i,
    output logic                     grant_vld_o,
    output logic                     st_vld_o,
    output logic [VC_W-1:0]          st_vc_id_o,
    output logic [QOS_W-1:0]         st_qos_o,
    input  logic                     credit_ret_vld_i,
    input  logic [VC_W-1:0]          credit_ret_vc_id_i,
    output logic [VC_NUM-1:0]        vc_avail_o,
    output logic [VC_NUM*CNT_W-1:0]  credit_cnt_o,
    output logic                     err_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(VC_DEPTH);

    logic [VC_NUM-1:0][CNT_W-1:0] cnt_q;
    logic [VC_NUM-1:0][CNT_W-1:0] cnt_d;
    logic [VC_NUM-1:0]            req_hit;
    logic [VC_NUM-1:0]            ret_hit;
    logic [VC_NUM-1:0]            gnt_hit;
    logic                         req_bad;
    logic                         ret_bad;
    logic                         ovf;

    // Per-VC decode and counter next-state; a grant and a return to the same VC cancel out.
    always_comb begin
        req_hit    = '0;
        ret_hit    = '0;
        gnt_hit    = '0;
        vc_avail_o = '0;
        cnt_d      = cnt_q;
        ovf        = 1'b0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            vc_avail_o[v] = (cnt_q[v] != '0);
            req_hit[v]    = req_vld_i && (req_vc_id_i == VC_W'(v));
            ret_hit[v]    = credit_ret_vld_i && (credit_ret_vc_id_i == VC_W'(v));
            gnt_hit[v]    = req_hit[v] && vc_avail_o[v];
            if (gnt_hit[v] && !ret_hit[v]) begin
                cnt_d[v] = cnt_q[v] - CNT_W'(1);
            end else if (ret_hit[v] && !gnt_hit[v]) begin
                if (cnt_q[v] == FULL) begin
                    ovf = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + CNT_W'(1);
                end
            end
        end
        req_bad      = req_vld_i && (32'(req_vc_id_i) >= VC_NUM);
        ret_bad      = credit_ret_vld_i && (32'(credit_ret_vc_id_i) >= VC_NUM);
        grant_vld_o  = rstn && (|gnt_hit);
        credit_cnt_o = cnt_q;
    end

    // Counters, traversal stage and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= {VC_NUM{FULL}};
            st_vld_o   <= 1'b0;
            st_vc_id_o <= '0;
            st_qos_o   <= '0;
            err_o      <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            st_vld_o <= |gnt_hit;
            if (|gnt_hit) begin
                st_vc_id_o <= req_vc_id_i;
                st_qos_o   <= req_qos_i;
            end
            err_o <= err_o | req_bad | ret_bad | ovf;
        end
    end

endmodule
